stdmacro_dffpipe: RTL

- Parametrised multi-stage register pipeline with a per-stage valid/ready handshake, bubble collapsing and synchronous flush.
- It is the next-generation successor of the single-stage DFF macro, generalised in data width, depth and reset value.
- It replaces hand-chained DFF macros on timing-critical datapaths, for example fetch-to-decode and LSU response paths.
- All flops use asynchronous active-low reset.

---
 rtl/stdmacro_dffpipe_if.sv | 23 ++
 rtl/stdmacro_dffpipe.sv | 100 ++++++++++
 2 files changed

// File: rtl/stdmacro_dffpipe_if.sv
// rtl/stdmacro_dffpipe_if.sv - upstream/downstream handshake bundle for the dffpipe register pipeline
interface stdmacro_dffpipe_if #(
    parameter int DFF_WIDTH = 1,
    parameter int CNT_WIDTH = 2
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DFF_WIDTH-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [DFF_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0] count;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, count
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, count
    );
endinterface

// File: rtl/stdmacro_dffpipe.sv
// rtl/stdmacro_dffpipe.sv - multi-stage valid/ready register pipeline with bubble collapsing and flush
module stdmacro_dffpipe #(
    parameter int                   DFF_WIDTH       = 1,
    parameter int                   DFF_DEPTH       = 2,
    parameter logic [DFF_WIDTH-1:0] DFF_RESET_VALUE = '0,
    parameter int                   CNT_WIDTH       = $clog2(DFF_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                flush,
    stdmacro_dffpipe_if.slave   pipe
);

    generate
        if (DFF_DEPTH < 1) begin : g_bad_depth
            $error("stdmacro_dffpipe: DFF_DEPTH must be >= 1");
        end
        if (DFF_WIDTH < 1) begin : g_bad_width
            $error("stdmacro_dffpipe: DFF_WIDTH must be >= 1");
        end
    endgenerate

    logic [DFF_DEPTH-1:0] v_q;
    logic [DFF_DEPTH-1:0] v_d;
    logic [DFF_WIDTH-1:0] d_q [DFF_DEPTH];
    logic [DFF_WIDTH-1:0] d_d [DFF_DEPTH];
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic [DFF_DEPTH-1:0] rdy;
    logic [DFF_DEPTH-1:0] in_v;
    logic [DFF_WIDTH-1:0] in_d [DFF_DEPTH];

    // A stage can take new data if it is empty or everything after it can move.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        acc = pipe.m_ready;
        for (int i = DFF_DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            rdy[i] = acc;
        end
    end

    always_comb begin : stage_inputs
        in_v    = '0;
        in_v[0] = pipe.s_valid;
        in_d[0] = pipe.s_data;
        for (int i = 1; i < DFF_DEPTH; i++) begin
            in_v[i] = v_q[i-1];
            in_d[i] = d_q[i-1];
        end
    end

    // Data only loads on a real transfer so bubbles leave the registers untouched.
    always_comb begin : next_state
        v_d   = v_q;
        cnt_d = '0;
        for (int i = 0; i < DFF_DEPTH; i++) begin
            d_d[i] = d_q[i];
        end
        if (flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < DFF_DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = in_v[i];
                    if (in_v[i]) begin
                        d_d[i] = in_d[i];
                    end
                end
            end
        end
        for (int i = 0; i < DFF_DEPTH; i++) begin
            cnt_d = cnt_d + CNT_WIDTH'(v_d[i]);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DFF_DEPTH; i++) begin
                d_q[i] <= DFF_RESET_VALUE;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < DFF_DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign pipe.s_ready = rdy[0] & ~flush & aresetn;
    assign pipe.m_valid = v_q[DFF_DEPTH-1];
    assign pipe.m_data  = d_q[DFF_DEPTH-1];
    assign pipe.count   = cnt_q;

endmodule
